// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined two-operand comparator with valid/ready flow control.
//
// A request {in_op, in_a, in_b, in_tag} is compared combinationally at
// acceptance and the {result, err, tag} triple then travels through STAGES
// register slots. The last slot drives the out_* ports. Bubbles collapse, so
// with out_ready held high the pipe sustains one result per cycle at a
// latency of STAGES cycles.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   flush                synchronous squash of every in-flight entry
//   in_valid/in_ready    request handshake
//   in_op                0 EQ 1 NE 2 LT 3 LE 4 GT 5 GE (signed),
//                        6 LTU 7 LEU 8 GTU 9 GEU, 10..15 illegal (err=1)
//   in_a, in_b           WIDTH-bit operands
//   in_tag               sideband tag, returned unchanged
//   out_valid/out_ready  result handshake
//   out_result, out_err  comparison result and illegal-op flag
//   out_tag              tag of the presented result
//   busy                 some stage holds a valid entry
module cmp_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef struct packed {
        logic             result;
        logic             err;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [STAGES-1:0] vld_pipe;
    entry_t            stage_q  [STAGES];
    entry_t            src      [STAGES];
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] can_load;
    entry_t            new_entry;

    // Comparison of the incoming operands
    logic eq, lt_s, lt_u;

    assign eq   = (in_a == in_b);
    assign lt_u = (in_a < in_b);
    assign lt_s = ($signed(in_a) < $signed(in_b));

    always_comb begin
        new_entry        = '0;
        new_entry.tag    = in_tag;
        case (in_op)
            4'd0:    new_entry.result = eq;
            4'd1:    new_entry.result = !eq;
            4'd2:    new_entry.result = lt_s;
            4'd3:    new_entry.result = lt_s || eq;
            4'd4:    new_entry.result = !(lt_s || eq);
            4'd5:    new_entry.result = !lt_s;
            4'd6:    new_entry.result = lt_u;
            4'd7:    new_entry.result = lt_u || eq;
            4'd8:    new_entry.result = !(lt_u || eq);
            4'd9:    new_entry.result = !lt_u;
            default: new_entry.err    = 1'b1;
        endcase
    end

    // Load-enable chain, computed from the output backwards: a stage can take
    // new data when it is empty or when its own entry moves on this cycle.
    // Kept in one process so the ripple is a single combinational block.
    always_comb begin
        can_load             = '0;
        can_load[STAGES-1]   = !vld_pipe[STAGES-1] || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            can_load[i] = !vld_pipe[i] || can_load[i+1];
        end
    end

    // Source of each stage: the request for stage 0, the previous slot otherwise
    always_comb begin
        src_vld    = '0;
        src[0]     = new_entry;
        src_vld[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            src[i]     = stage_q[i-1];
            src_vld[i] = vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush) begin
                    vld_pipe[i] <= 1'b0;
                end else if (can_load[i]) begin
                    vld_pipe[i] <= src_vld[i];
                    // Data only follows a valid source so a drained output
                    // slot keeps its last value instead of toggling.
                    if (src_vld[i]) begin
                        stage_q[i] <= src[i];
                    end
                end
            end
        end
    end

    // in_ready depends on out_ready combinationally through can_load
    assign in_ready   = can_load[0];
    assign out_valid  = vld_pipe[STAGES-1];
    assign out_result = stage_q[STAGES-1].result;
    assign out_err    = stage_q[STAGES-1].err;
    assign out_tag    = stage_q[STAGES-1].tag;
    assign busy       = |vld_pipe;

endmodule

// File: tb/tb_cmp_pipe.sv
// Testbench for cmp_pipe (WIDTH=32, STAGES=2, TAG_W=5).
// Accepted requests push an expected {result, err, tag, cycle} onto a
// scoreboard; each output handshake pops and compares.
module tb_cmp_pipe;

    localparam int W  = 32;
    localparam int ST = 2;
    localparam int TW = 5;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic          out_result;
    logic          out_err;
    logic [TW-1:0] out_tag;
    logic          busy;

    cmp_pipe #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Reference model: widen to 64 bits and compare as plain integers
    function automatic logic [1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        longint sa, sb2, ua, ub;
        logic   r;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        case (op)
            4'd0: r = (sa == sb2);
            4'd1: r = (sa != sb2);
            4'd2: r = (sa <  sb2);
            4'd3: r = (sa <= sb2);
            4'd4: r = (sa >  sb2);
            4'd5: r = (sa >= sb2);
            4'd6: r = (ua <  ub);
            4'd7: r = (ua <= ub);
            4'd8: r = (ua >  ub);
            4'd9: r = (ua >= ub);
            default: return 2'b01;
        endcase
        return {r, 1'b0};
    endfunction

    typedef struct {
        logic          res;
        logic          err;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    bit   lat_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    logic          stall_prev = 0;
    logic          prev_res, prev_err;
    logic [TW-1:0] prev_tag;

    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev && out_valid) begin
                chk("stable_res", out_result, prev_res);
                chk("stable_err", out_err, prev_err);
                chk("stable_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("err", out_err, e.err);
                    chk("tag", out_tag, e.tag);
                    if (lat_on) chk("latency", cyc - e.cyc, ST);
                end
            end
            if (in_valid && in_ready && !flush) begin
                exp_t e;
                logic [1:0] m;
                m = model(in_op, in_a, in_b);
                e.res = m[1];
                e.err = m[0];
                e.tag = in_tag;
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (flush) sb.delete();
            stall_prev = out_valid && !out_ready;
            prev_res   = out_result;
            prev_err   = out_err;
            prev_tag   = out_tag;
        end else begin
            stall_prev = 0;
        end
    end

    // Present a request and hold it until accepted (bounded)
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input bit want_rdy, input bit rnd);
        logic acc;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int t = 0; t < 200; t++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            if (want_rdy) chk("in_ready_stream", in_ready, 1);
            @(posedge clk);
            #1;
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Single signed LT: -1 < 1
        lat_on = 1;
        send(4'd2, 32'hFFFF_FFFF, 32'h1, 5'd3, 1, 0);
        idle();
        drain();

        // Back-to-back stream, results 0,1,0,0
        send(4'd6, 32'hFFFF_FFFF, 32'h1, 5'd4, 1, 0);
        send(4'd9, 32'hFFFF_FFFF, 32'h1, 5'd5, 1, 0);
        send(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd6, 1, 0);
        send(4'd5, 32'hFFFF_FFFF, 32'h1, 5'd7, 1, 0);
        idle();
        drain();

        // Illegal ops and LE on equal negative extremes
        send(4'd12, 32'h5, 32'h9, 5'd8, 1, 0);
        send(4'd15, 32'h9, 32'h5, 5'd9, 1, 0);
        send(4'd3, 32'h8000_0000, 32'h8000_0000, 5'd10, 1, 0);
        send(4'd8, 32'h8000_0000, 32'h7FFF_FFFF, 5'd11, 1, 0);
        send(4'd4, 32'h8000_0000, 32'h7FFF_FFFF, 5'd12, 1, 0);
        idle();
        drain();

        // Backpressure: only STAGES entries fit
        lat_on    = 0;
        out_ready = 1'b0;
        n         = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_op    = 4'(k + 6);
            in_a     = 32'(k * 7);
            in_b     = 32'h10;
            in_tag   = 5'(16 + n);
            @(negedge clk);
            if (k >= 2) chk("bp_in_ready_low", in_ready, 0);
            if (in_ready) n++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", n, 2);
        out_ready = 1'b1;
        #1 chk("bp_in_ready_back", in_ready, 1);
        @(posedge clk);
        #1 idle();
        drain();

        // Flush with two in flight and a request in the flush cycle
        out_ready = 1'b0;
        send(4'd0, 32'h1, 32'h1, 5'd20, 0, 0);
        send(4'd1, 32'h1, 32'h1, 5'd21, 0, 0);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_tag   = 5'd31;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("flush_sb_empty", sb.size(), 0);

        // Asynchronous reset with two in flight
        out_ready = 1'b0;
        send(4'd2, 32'h3, 32'h4, 5'd22, 0, 0);
        send(4'd6, 32'h3, 32'h4, 5'd23, 0, 0);
        idle();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        sb.delete();
        @(posedge clk);
        #1 reset  = 1'b1;
        out_ready = 1'b1;
        lat_on    = 1;
        send(4'd7, 32'h4, 32'h4, 5'd24, 1, 0);
        idle();
        drain();

        // Random traffic with random backpressure
        lat_on = 0;
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            send(4'($urandom_range(0, 15)), a, b, 5'($urandom), 0, 1);
        end
        idle();
        out_ready = 1'b1;
        drain();
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator.
- Compares two WIDTH-bit operands under a 4-bit op code, signed or unsigned.
- Carries the result and a tag through STAGES registered stages with valid/ready flow control.
- Sits between operand forwarding and branch resolution in the deeper-pipeline core; also usable by the multi-cycle unit for slt/sltu-style results.

Parameters:
- WIDTH, 32, operand width in bits (legal 2..64)
- STAGES, 2, number of pipeline register stages = result latency in cycles (legal 1..4)
- TAG_W, 5, width of the sideband tag carried with each compare (legal 1..16)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all in-flight entries
- in_valid  input  1  request present
- in_ready  output  1  request accepted this cycle when in_valid && in_ready
- in_op  input  4  comparison op code
- in_a  input  WIDTH  operand 1
- in_b  input  WIDTH  operand 2
- in_tag  input  TAG_W  sideband tag, returned unchanged
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_result  output  1  comparison result
- out_err  output  1  in_op was illegal
- out_tag  output  TAG_W  tag of this result
- busy  output  1  any stage holds a valid entry

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low.
- Reset values: while reset is low, all stage valid bits clear and all stage data clears. Hence out_valid=0, out_result=0, out_err=0, out_tag=0, busy=0. in_ready=1 once reset deasserts.
- Op encoding:
  - Signed: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE (two's complement).
  - Unsigned: 6 LTU, 7 LEU, 8 GTU, 9 GEU.
  - 10..15 illegal: result=0, err=1. This replaces the old x default; the result is always a defined value.
- Result timing: evaluated combinationally from the inputs at acceptance. Result, err and tag are written into stage 0.
- Stages: STAGES register slots, each {valid, result, err, tag}. Stage STAGES-1 drives the out_* ports.
- Advance rule:
  - Last stage drains when out_valid && out_ready.
  - Stage i may load when it is empty or draining this cycle.
  - Stage i loads from stage i-1 whenever stage i-1 is valid and stage i can load (bubbles collapse).
  - in_ready = stage 0 empty, or stage 0 moving forward this cycle. This is a combinational path from out_ready; it is accepted.
- Latency and throughput: with out_ready held high, a request accepted in cycle N has out_valid=1 in cycle N+STAGES. Full throughput is 1 result/cycle.
- Backpressure:
  - While out_valid && !out_ready, out_result, out_err and out_tag stay stable.
  - Upstream stages keep filling until all STAGES slots are full, then in_ready=0.
  - No entry is ever dropped or duplicated.
- Flush:
  - At the next edge, all valid bits clear. A request presented in the flush cycle is not captured, even if in_valid && in_ready.
  - out_valid falls the cycle after flush. The out_ready handshake in the flush cycle still counts as consumed.
- busy: OR of all stage valid bits.
- Reset mid-operation: all in-flight entries are lost immediately (asynchronous). There is no partial output.
- Width rules:
  - Signed ops treat bit WIDTH-1 as the sign bit.
  - Unsigned ops zero-extend.
  - EQ/NE compare all WIDTH bits.
- Ordering: results leave in acceptance order. Tags are not interpreted.

Test Plan:
1. STAGES=2, out_ready=1: accept op=2, a=0xFFFFFFFF, b=0x00000001, tag=3 in cycle N -> cycle N+2: out_valid=1, out_result=1, out_err=0, out_tag=3.
2. Stream ops 6,9,0,5 with a=0xFFFFFFFF, b=1 on consecutive cycles -> results 0,1,0,0 on consecutive cycles N+2..N+5, tags in order, in_ready stays 1.
3. out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 entries accepted, then in_ready=0; out_result and out_tag stable. out_ready=1 -> drains 1/cycle, in_ready returns high the same cycle.
4. in_op=12 and in_op=15 -> out_result=0, out_err=1. in_op=3 with a=b=0x80000000 -> result 1, err 0.
5. Two entries in flight, assert flush for 1 cycle together with a new valid request -> next cycle out_valid=0, busy=0, and the flush-cycle request never appears.
6. Drop reset low asynchronously between edges with 2 entries in flight -> out_valid and busy fall immediately without a clock edge. After release, the first new request returns after STAGES cycles with correct values.
